// File: rtl/obstacle_edge_scheduler.sv
// obstacle_edge_scheduler: per-frame obstacle fetch sequencing and polygon-to-edge serialisation
// with a registered valid/ready edge stream.
module obstacle_edge_scheduler #(
   parameter int WORLD_BITS = 32,
   parameter int MAX_NUM_VERTICES = 8,
   parameter int MAX_OBSTACLES_ON_SCREEN = 16
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic frame_start_in,
   output logic obs_next_out,
   input  logic obs_ready_in,
   output logic obs_done_out,
   input  logic signed [WORLD_BITS-1:0] obstacles_in [MAX_OBSTACLES_ON_SCREEN][MAX_NUM_VERTICES],
   input  logic [$clog2(MAX_NUM_VERTICES+1)-1:0] obstacles_num_sides_in [MAX_OBSTACLES_ON_SCREEN],
   input  logic [$clog2(MAX_OBSTACLES_ON_SCREEN+1)-1:0] num_obstacles_in,
   output logic edge_valid_out,
   input  logic edge_ready_in,
   output logic signed [WORLD_BITS-1:0] edge_a_out,
   output logic signed [WORLD_BITS-1:0] edge_b_out,
   output logic [$clog2(MAX_OBSTACLES_ON_SCREEN)-1:0] edge_obs_idx_out,
   output logic edge_last_out,
   output logic busy_out,
   output logic frame_done_out
);
   localparam int SW = $clog2(MAX_NUM_VERTICES + 1);
   localparam int CW = $clog2(MAX_OBSTACLES_ON_SCREEN + 1);
   localparam int IW = $clog2(MAX_OBSTACLES_ON_SCREEN);
   localparam int VW = $clog2(MAX_NUM_VERTICES);
   localparam logic [SW-1:0] NMAX = SW'(MAX_NUM_VERTICES);
   localparam logic [CW-1:0] CMAX = CW'(MAX_OBSTACLES_ON_SCREEN);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, FINISH} state_t;

   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_live, cnt_eff, i, i_nx;
   logic [SW-1:0] j, j_nx, n_cur, n_nx, last_cur, last_nx;
   logic [VW-1:0] bj;
   logic load, adv;

   function automatic logic [SW-1:0] clamp_n(input logic [SW-1:0] n);
      return n > NMAX ? NMAX : n;
   endfunction

   // index of the final edge of an obstacle: a 2-gon has a single edge
   function automatic logic [SW-1:0] last_of(input logic [SW-1:0] n);
      return n == SW'(2) ? '0 : n - 1'b1;
   endfunction

   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      i_nx = i;
      j_nx = j;
      load = 1'b0;
      cnt_live = num_obstacles_in > CMAX ? CMAX : num_obstacles_in;
      cnt_eff = state == WAIT ? cnt_live : cnt;
      n_cur = clamp_n(obstacles_num_sides_in[i[IW-1:0]]);
      last_cur = last_of(n_cur);
      adv = state == EMIT && (!edge_valid_out || edge_ready_in);
      case (state)
         IDLE: state_nx = frame_start_in ? REQ : IDLE;
         REQ: state_nx = WAIT;
         WAIT:
            if (obs_ready_in) begin
               i_nx = '0;
               j_nx = '0;
               load = cnt_live != '0;
               state_nx = cnt_live == '0 ? FINISH : EMIT;
            end
         EMIT:
            if (adv) begin
               if (edge_valid_out && j != last_cur) j_nx = j + 1'b1;
               else begin
                  i_nx = i + 1'b1;
                  j_nx = '0;
               end
               load = i_nx != cnt;
               state_nx = i_nx == cnt ? FINISH : EMIT;
            end
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      n_nx = clamp_n(obstacles_num_sides_in[i_nx[IW-1:0]]);
      last_nx = last_of(n_nx);
      bj = j_nx == n_nx - 1'b1 ? '0 : VW'(j_nx + 1'b1);
      obs_next_out = state == REQ;
      obs_done_out = state == FINISH;
      frame_done_out = state == FINISH;
      busy_out = state != IDLE;
   end

   // payload for (i_nx, j_nx) is registered so it holds steady under backpressure
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         cnt <= '0;
         i <= '0;
         j <= '0;
         edge_valid_out <= 1'b0;
         edge_a_out <= '0;
         edge_b_out <= '0;
         edge_obs_idx_out <= '0;
         edge_last_out <= 1'b0;
      end else begin
         i <= i_nx;
         j <= j_nx;
         if (state == WAIT && obs_ready_in) cnt <= cnt_live;
         if (load) begin
            edge_valid_out <= n_nx >= SW'(2);
            edge_a_out <= obstacles_in[i_nx[IW-1:0]][j_nx[VW-1:0]];
            edge_b_out <= obstacles_in[i_nx[IW-1:0]][bj];
            edge_obs_idx_out <= i_nx[IW-1:0];
            edge_last_out <= n_nx >= SW'(2) && i_nx == cnt_eff - 1'b1 && j_nx == last_nx;
         end else if (adv) begin
            edge_valid_out <= 1'b0;
            edge_last_out <= 1'b0;
         end
      end
endmodule

// File: tb/tb_obstacle_edge_scheduler.sv
// tb_obstacle_edge_scheduler: directed frames with hand-computed edge lists and cycle timings.
module tb_obstacle_edge_scheduler;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic frame_start_in = 1'b0;
   logic obs_ready_in = 1'b0;
   logic edge_ready_in = 1'b1;
   logic obs_next_out, obs_done_out, edge_valid_out, edge_last_out, busy_out, frame_done_out;
   logic signed [31:0] obs [16][8];
   logic [3:0] sides [16];
   logic [4:0] num;
   logic signed [31:0] edge_a_out, edge_b_out;
   logic [3:0] edge_obs_idx_out;

   int checks = 0, failures = 0, cyc = 0;
   int t0, u, nxt_n, nxt_cyc, fd_n, fd_cyc, od_n, od_cyc, bad;
   bit rdy_rand = 0, prev_stall = 0;
   logic signed [31:0] pa, pb;
   logic [3:0] pidx;
   logic plast;
   logic signed [31:0] ea[$], eb[$];
   logic [3:0] eidx[$];
   logic elast[$];
   int ec[$];

   obstacle_edge_scheduler dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
      .obs_next_out(obs_next_out), .obs_ready_in(obs_ready_in), .obs_done_out(obs_done_out),
      .obstacles_in(obs), .obstacles_num_sides_in(sides), .num_obstacles_in(num),
      .edge_valid_out(edge_valid_out), .edge_ready_in(edge_ready_in),
      .edge_a_out(edge_a_out), .edge_b_out(edge_b_out), .edge_obs_idx_out(edge_obs_idx_out),
      .edge_last_out(edge_last_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   always @(posedge clk_in) begin
      #1;
      edge_ready_in = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (prev_stall)
            check("stall_hold", {edge_valid_out, edge_a_out, edge_b_out, edge_obs_idx_out, edge_last_out},
                  {1'b1, pa, pb, pidx, plast});
         if (edge_valid_out && edge_ready_in) begin
            ea.push_back(edge_a_out);
            eb.push_back(edge_b_out);
            eidx.push_back(edge_obs_idx_out);
            elast.push_back(edge_last_out);
            ec.push_back(cyc);
         end
         if (obs_next_out) begin nxt_n++; nxt_cyc = cyc; end
         if (frame_done_out) begin fd_n++; fd_cyc = cyc; end
         if (obs_done_out) begin od_n++; od_cyc = cyc; end
         prev_stall = edge_valid_out && !edge_ready_in;
         pa = edge_a_out;
         pb = edge_b_out;
         pidx = edge_obs_idx_out;
         plast = edge_last_out;
      end else prev_stall = 0;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_cfg();
      for (int o = 0; o < 16; o++) begin
         sides[o] = '0;
         for (int v = 0; v < 8; v++) obs[o][v] = 32'(o * 16 + v);
      end
      num = '0;
   endtask

   task automatic run_frame(input int delay, input int fs_at);
      ea.delete(); eb.delete(); eidx.delete(); elast.delete(); ec.delete();
      nxt_n = 0; fd_n = 0; od_n = 0; fd_cyc = 0; od_cyc = 0; nxt_cyc = 0;
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      t0 = cyc;
      repeat (delay) tick();
      obs_ready_in = 1'b1;
      u = cyc;
      for (int k = 0; k < 400 && fd_n == 0; k++) begin
         frame_start_in = k == fs_at;
         tick();
      end
      frame_start_in = 1'b0;
      obs_ready_in = 1'b0;
      check("frame_done_seen", fd_n != 0, 1);
      check("busy_after", busy_out, 0);
   endtask

   task automatic check_edge(input string tag, input int k, input int a, input int b,
                             input logic [3:0] idx, input logic last, input int rel);
      if (k < ea.size()) begin
         check(tag, {ea[k], eb[k], eidx[k], elast[k]}, {a[31:0], b[31:0], idx, last});
         check({tag, "_cyc"}, ec[k] - u, rel);
      end
   endtask

   initial begin
      clear_cfg();
      repeat (3) tick();
      check("reset_outs", {edge_valid_out, edge_a_out, edge_b_out, edge_obs_idx_out, edge_last_out,
                           busy_out, obs_next_out, obs_done_out, frame_done_out}, 0);
      rst_in = 1'b0;
      tick();

      clear_cfg();
      num = 1; sides[0] = 3; obs[0][0] = 10; obs[0][1] = 20; obs[0][2] = 30;
      run_frame(1, -1);
      check("tri_nedges", ea.size(), 3);
      check("tri_next_cyc", nxt_cyc, t0);
      check("tri_next_n", nxt_n, 1);
      check_edge("tri_e0", 0, 10, 20, 0, 0, 1);
      check_edge("tri_e1", 1, 20, 30, 0, 0, 2);
      check_edge("tri_e2", 2, 30, 10, 0, 1, 3);
      check("tri_fd_cyc", fd_cyc - u, 4);
      check("tri_od_cyc", od_cyc - u, 4);

      clear_cfg();
      num = 2; sides[0] = 3; sides[1] = 4;
      for (int v = 0; v < 4; v++) begin obs[0][v] = 100 + v; obs[1][v] = 200 + v; end
      rdy_rand = 1;
      run_frame(2, -1);
      rdy_rand = 0;
      check("bp_nedges", ea.size(), 7);
      if (ea.size() == 7) begin
         check("bp_e0", {ea[0], eb[0], eidx[0], elast[0]}, {32'd100, 32'd101, 4'd0, 1'b0});
         check("bp_e1", {ea[1], eb[1], eidx[1], elast[1]}, {32'd101, 32'd102, 4'd0, 1'b0});
         check("bp_e2", {ea[2], eb[2], eidx[2], elast[2]}, {32'd102, 32'd100, 4'd0, 1'b0});
         check("bp_e3", {ea[3], eb[3], eidx[3], elast[3]}, {32'd200, 32'd201, 4'd1, 1'b0});
         check("bp_e4", {ea[4], eb[4], eidx[4], elast[4]}, {32'd201, 32'd202, 4'd1, 1'b0});
         check("bp_e5", {ea[5], eb[5], eidx[5], elast[5]}, {32'd202, 32'd203, 4'd1, 1'b0});
         check("bp_e6", {ea[6], eb[6], eidx[6], elast[6]}, {32'd203, 32'd200, 4'd1, 1'b1});
         check("bp_fd_cyc", fd_cyc - ec[6], 1);
      end

      clear_cfg();
      num = 0;
      run_frame(3, -1);
      check("zero_nedges", ea.size(), 0);
      check("zero_fd_cyc", fd_cyc - u, 1);
      check("zero_od_cyc", od_cyc - u, 1);
      check("zero_od_n", od_n, 1);

      clear_cfg();
      num = 4; sides[0] = 1; sides[1] = 2; sides[2] = 0; sides[3] = 3;
      obs[1][0] = 11; obs[1][1] = 12; obs[3][0] = 31; obs[3][1] = 32; obs[3][2] = 33;
      run_frame(1, -1);
      check("deg_nedges", ea.size(), 4);
      check_edge("deg_e0", 0, 11, 12, 1, 0, 2);
      check_edge("deg_e1", 1, 31, 32, 3, 0, 4);
      check_edge("deg_e2", 2, 32, 33, 3, 0, 5);
      check_edge("deg_e3", 3, 33, 31, 3, 1, 6);
      check("deg_fd_cyc", fd_cyc - u, 7);

      clear_cfg();
      num = 2; sides[0] = 3;
      run_frame(1, -1);
      check("trail_nedges", ea.size(), 3);
      check_edge("trail_e2", 2, 2, 0, 0, 0, 3);
      check("trail_fd_cyc", fd_cyc - u, 5);

      clear_cfg();
      num = 20;
      for (int o = 0; o < 16; o++) sides[o] = 9;
      run_frame(1, -1);
      check("clamp_nedges", ea.size(), 128);
      bad = 0;
      for (int k = 0; k < ea.size() && k < 128; k++)
         if ({ea[k], eb[k], eidx[k], elast[k]} !== {32'(k / 8 * 16 + k % 8), 32'(k / 8 * 16 + (k % 8 + 1) % 8),
                                                    4'(k / 8), k == 127}) bad++;
      check("clamp_edges_bad", bad, 0);

      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      tick();
      obs_ready_in = 1'b1;
      repeat (20) tick();
      check("pre_rst_valid", edge_valid_out, 1);
      rst_in = 1'b1;
      #1;
      check("rst_mid_outs", {edge_valid_out, edge_a_out, edge_b_out, edge_obs_idx_out, edge_last_out,
                             busy_out, obs_next_out, obs_done_out, frame_done_out}, 0);
      tick();
      rst_in = 1'b0;
      obs_ready_in = 1'b0;
      tick();
      run_frame(1, 10);
      check("restart_nedges", ea.size(), 128);
      if (ea.size() > 0) check("restart_e0", {ea[0], eb[0], eidx[0]}, {32'd0, 32'd1, 4'd0});
      check("busy_start_next_n", nxt_n, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
